// File: rtl/pkt_bufid_allocator_pkg.sv
// pkt_bufid_allocator_pkg: sizing defaults and FSM encoding shared by the allocator, release stage and FIFO/RAM wrappers.
package pkt_bufid_allocator_pkg;
    localparam int PORT_NUM_D = 9;
    localparam int BUFID_W_D = 9;
    localparam int CNT_W_D = 4;
    typedef enum logic [1:0] {
        ARB_S   = 2'd0,
        RD_S    = 2'd1,
        WAIT_S  = 2'd2,
        GRANT_S = 2'd3
    } alloc_state_t;
endpackage

// File: rtl/pkt_bufid_allocator_rr_arbiter.sv
// rr_arbiter_9: combinational round-robin pick of the first request at or after ptr, wrapping at N-1.
module rr_arbiter_9 #(
    parameter int N = 9,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [N-1:0] rot;
    logic [IW-1:0] off;
    logic [IW:0] sum;
    always_comb begin
        rot = N'({req, req} >> ptr);
        valid = |rot;
        off = '0;
        for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end
endmodule

// File: rtl/pkt_bufid_allocator.sv
// pkt_bufid_allocator: pops free bufids and grants them round-robin to ingress ports,
// writing each packet's outport count into the reference-count RAM.
module pkt_bufid_allocator
    import pkt_bufid_allocator_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUM_D,
    parameter int BUFID_W = BUFID_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      i_hardware_initial_finish,
    input  logic [PORT_NUM-1:0]       iv_bufid_req,
    input  logic [PORT_NUM*CNT_W-1:0] iv_outport_num,
    output logic [PORT_NUM-1:0]       ov_bufid_ack,
    output logic [BUFID_W-1:0]        ov_bufid,
    output logic                      o_fifo_rd,
    input  logic [BUFID_W-1:0]        iv_fifo_rdata,
    input  logic                      i_fifo_empty,
    output logic                      o_cnt_wr,
    output logic [BUFID_W-1:0]        ov_cnt_addr,
    output logic [CNT_W-1:0]          ov_cnt_wdata,
    output logic [15:0]               ov_grant_cnt,
    output logic [1:0]                ov_alloc_state
);
    localparam int IW = $clog2(PORT_NUM);
    alloc_state_t state, nxt_state;
    logic [IW-1:0] ptr, nxt_ptr, win_idx, nxt_win_idx, arb_idx;
    logic [CNT_W-1:0] win_cnt, nxt_win_cnt, nxt_cnt_wdata;
    logic [PORT_NUM-1:0] nxt_ack;
    logic [BUFID_W-1:0] nxt_bufid, nxt_cnt_addr;
    logic [15:0] nxt_grant_cnt;
    logic arb_vld, nxt_rd, nxt_cnt_wr;
    rr_arbiter_9 #(.N(PORT_NUM), .IW(IW)) u_arb (
        .req   (iv_bufid_req),
        .ptr   (ptr),
        .idx   (arb_idx),
        .valid (arb_vld)
    );
    assign ov_alloc_state = state;
    always_comb begin
        nxt_state = state;
        nxt_ptr = ptr;
        nxt_win_idx = win_idx;
        nxt_win_cnt = win_cnt;
        nxt_rd = 1'b0;
        nxt_ack = '0;
        nxt_cnt_wr = 1'b0;
        nxt_bufid = ov_bufid;
        nxt_cnt_addr = ov_cnt_addr;
        nxt_cnt_wdata = ov_cnt_wdata;
        nxt_grant_cnt = ov_grant_cnt;
        case (state)
            ARB_S: if (i_hardware_initial_finish && !i_fifo_empty && arb_vld) begin
                nxt_win_idx = arb_idx;
                nxt_win_cnt = iv_outport_num[arb_idx*CNT_W +: CNT_W];
                nxt_rd = 1'b1;
                nxt_state = RD_S;
            end
            RD_S: nxt_state = WAIT_S;
            WAIT_S: begin
                nxt_bufid = iv_fifo_rdata;
                nxt_cnt_addr = iv_fifo_rdata;
                // a zero outport count still needs one release to free the buffer
                nxt_cnt_wdata = (win_cnt == '0) ? CNT_W'(1) : win_cnt;
                nxt_cnt_wr = 1'b1;
                nxt_ack = PORT_NUM'(1) << win_idx;
                nxt_grant_cnt = ov_grant_cnt + 16'd1;
                nxt_ptr = (win_idx == IW'(PORT_NUM - 1)) ? '0 : win_idx + 1'b1;
                nxt_state = GRANT_S;
            end
            default: nxt_state = ARB_S;
        endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_S;
            ptr <= '0;
            win_idx <= '0;
            win_cnt <= '0;
            o_fifo_rd <= 1'b0;
            ov_bufid_ack <= '0;
            o_cnt_wr <= 1'b0;
            ov_bufid <= '0;
            ov_cnt_addr <= '0;
            ov_cnt_wdata <= '0;
            ov_grant_cnt <= '0;
        end else begin
            state <= nxt_state;
            ptr <= nxt_ptr;
            win_idx <= nxt_win_idx;
            win_cnt <= nxt_win_cnt;
            o_fifo_rd <= nxt_rd;
            ov_bufid_ack <= nxt_ack;
            o_cnt_wr <= nxt_cnt_wr;
            ov_bufid <= nxt_bufid;
            ov_cnt_addr <= nxt_cnt_addr;
            ov_cnt_wdata <= nxt_cnt_wdata;
            ov_grant_cnt <= nxt_grant_cnt;
        end
    end
endmodule

// File: tb/tb_pkt_bufid_allocator.sv
// tb_pkt_bufid_allocator: scoreboard bench with a free-FIFO model and auto-dropping requesters.
module tb_pkt_bufid_allocator;
    localparam int P = 9;
    localparam int BW = 9;
    localparam int CW = 4;
    typedef struct {
        int port;
        logic [BW-1:0] bufid;
        logic [CW-1:0] cnt;
    } exp_t;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic i_hardware_initial_finish;
    logic [P-1:0] iv_bufid_req;
    logic [P*CW-1:0] iv_outport_num;
    logic [P-1:0] ov_bufid_ack;
    logic [BW-1:0] ov_bufid;
    logic o_fifo_rd;
    logic [BW-1:0] iv_fifo_rdata;
    logic i_fifo_empty;
    logic o_cnt_wr;
    logic [BW-1:0] ov_cnt_addr;
    logic [CW-1:0] ov_cnt_wdata;
    logic [15:0] ov_grant_cnt;
    logic [1:0] ov_alloc_state;
    exp_t sb[$];
    logic [BW-1:0] fifo_q[$];
    int tests = 0, fails = 0, cyc = 0, grants = 0, pops = 0, ack_cyc = 0, rd_cyc = 0, t0 = 0;
    bit pop_pend = 0, rereq = 0;
    logic [P-1:0] pend_req = '0;
    always #5 clk_sys = ~clk_sys;
    pkt_bufid_allocator dut (
        .clk_sys                   (clk_sys),
        .reset_n                   (reset_n),
        .i_hardware_initial_finish (i_hardware_initial_finish),
        .iv_bufid_req              (iv_bufid_req),
        .iv_outport_num            (iv_outport_num),
        .ov_bufid_ack              (ov_bufid_ack),
        .ov_bufid                  (ov_bufid),
        .o_fifo_rd                 (o_fifo_rd),
        .iv_fifo_rdata             (iv_fifo_rdata),
        .i_fifo_empty              (i_fifo_empty),
        .o_cnt_wr                  (o_cnt_wr),
        .ov_cnt_addr               (ov_cnt_addr),
        .ov_cnt_wdata              (ov_cnt_wdata),
        .ov_grant_cnt              (ov_grant_cnt),
        .ov_alloc_state            (ov_alloc_state)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic push_grant(input int port, input logic [BW-1:0] bufid, input logic [CW-1:0] cnt);
        exp_t e;
        e.port = port;
        e.bufid = bufid;
        e.cnt = cnt;
        sb.push_back(e);
        fifo_q.push_back(bufid);
        iv_outport_num[port*CW +: CW] = cnt;
    endtask
    task automatic tick();
        exp_t e;
        @(negedge clk_sys);
        cyc++;
        iv_bufid_req = iv_bufid_req | pend_req;
        pend_req = '0;
        if (pop_pend) begin
            pop_pend = 0;
            iv_fifo_rdata = (fifo_q.size() > 0) ? fifo_q.pop_front() : '1;
        end
        if (o_fifo_rd) begin
            pops++;
            rd_cyc = cyc;
            pop_pend = 1;
            check("rd_while_empty", 32'(i_fifo_empty), 0);
        end
        if (ov_bufid_ack != '0) begin
            grants++;
            ack_cyc = cyc;
            if (sb.size() == 0) check("unexpected_ack", 32'(ov_bufid_ack), 0);
            else begin
                e = sb.pop_front();
                check("ack_port", 32'(ov_bufid_ack), 32'(1) << e.port);
                check("bufid", 32'(ov_bufid), 32'(e.bufid));
                check("cnt_wr", 32'(o_cnt_wr), 1);
                check("cnt_addr", 32'(ov_cnt_addr), 32'(e.bufid));
                check("cnt_wdata", 32'(ov_cnt_wdata), (e.cnt == 0) ? 32'd1 : 32'(e.cnt));
            end
            iv_bufid_req = iv_bufid_req & ~ov_bufid_ack;
            if (rereq) pend_req = ov_bufid_ack;
        end
    endtask
    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (grants < n && t < budget) begin
            tick();
            t++;
        end
        check("grant_count", grants, n);
    endtask
    initial begin
        reset_n = 1'b0;
        i_hardware_initial_finish = 1'b0;
        iv_bufid_req = '0;
        iv_outport_num = '0;
        iv_fifo_rdata = '0;
        i_fifo_empty = 1'b1;
        repeat (3) tick();
        check("rst_state", 32'(ov_alloc_state), 0);
        check("rst_ack", 32'(ov_bufid_ack), 0);
        check("rst_rd", 32'(o_fifo_rd), 0);
        check("rst_wr", 32'(o_cnt_wr), 0);
        check("rst_gcnt", 32'(ov_grant_cnt), 0);
        reset_n = 1'b1;
        // init gating, then exact latency
        i_fifo_empty = 1'b0;
        push_grant(3, 9'd9, 4'd2);
        iv_bufid_req[3] = 1'b1;
        repeat (50) tick();
        check("gate_no_rd", pops, 0);
        i_hardware_initial_finish = 1'b1;
        tick();
        check("gate_rd", 32'(o_fifo_rd), 1);
        tick();
        check("rd_pulse", 32'(o_fifo_rd), 0);
        tick();
        check("gate_ack", 32'(ov_bufid_ack), 32'h008);
        check("gate_lat", ack_cyc - rd_cyc, 2);
        tick();
        check("ack_pulse", 32'(ov_bufid_ack), 0);
        check("wr_pulse", 32'(o_cnt_wr), 0);
        check("bufid_hold", 32'(ov_bufid), 9);
        check("state_arb", 32'(ov_alloc_state), 0);
        // reference RAM write, including zero count
        push_grant(0, 9'd25, 4'd4);
        iv_bufid_req[0] = 1'b1;
        wait_grants(2, 20);
        push_grant(0, 9'd26, 4'd0);
        iv_bufid_req[0] = 1'b1;
        wait_grants(3, 20);
        // round robin from pointer 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        grants = 0;
        pops = 0;
        push_grant(1, 9'd100, 4'd1);
        push_grant(5, 9'd101, 4'd5);
        push_grant(8, 9'd102, 4'd8);
        push_grant(1, 9'd103, 4'd1);
        push_grant(5, 9'd104, 4'd5);
        push_grant(8, 9'd105, 4'd8);
        rereq = 1;
        iv_bufid_req = 9'b100100010;
        wait_grants(6, 60);
        rereq = 0;
        pend_req = '0;
        iv_bufid_req = '0;
        check("rr_gcnt", 32'(ov_grant_cnt), 6);
        check("rr_pops", pops, 6);
        repeat (8) tick();
        check("rr_no_extra", grants, 6);
        // pointer wrapped to 0 after the p8 grant
        push_grant(0, 9'd110, 4'd3);
        push_grant(1, 9'd111, 4'd2);
        iv_bufid_req = 9'b000000011;
        wait_grants(8, 30);
        // empty FIFO holds the request
        i_fifo_empty = 1'b1;
        push_grant(2, 9'd120, 4'd6);
        iv_bufid_req[2] = 1'b1;
        repeat (20) tick();
        check("empty_no_ack", grants, 8);
        check("empty_no_rd", pops, 8);
        i_fifo_empty = 1'b0;
        t0 = cyc;
        wait_grants(9, 10);
        check("empty_lat", ack_cyc - t0, 3);
        // grant counter wrap
        force dut.ov_grant_cnt = 16'hFFFF;
        tick();
        release dut.ov_grant_cnt;
        tick();
        check("gcnt_preload", 32'(ov_grant_cnt), 32'hFFFF);
        push_grant(6, 9'd130, 4'd1);
        iv_bufid_req[6] = 1'b1;
        wait_grants(10, 20);
        check("gcnt_wrap", 32'(ov_grant_cnt), 0);
        // asynchronous reset in WAIT_S
        fifo_q.push_back(9'd140);
        iv_outport_num[4*CW +: CW] = 4'd2;
        iv_bufid_req[4] = 1'b1;
        t0 = 0;
        while (ov_alloc_state != 2'd2 && t0 < 10) begin
            tick();
            t0++;
        end
        check("reach_wait", 32'(ov_alloc_state), 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(ov_alloc_state), 0);
        check("mid_rst_ack", 32'(ov_bufid_ack), 0);
        check("mid_rst_wr", 32'(o_cnt_wr), 0);
        check("mid_rst_bufid", 32'(ov_bufid), 0);
        check("mid_rst_addr", 32'(ov_cnt_addr), 0);
        check("mid_rst_wdata", 32'(ov_cnt_wdata), 0);
        iv_bufid_req = '0;
        fifo_q.delete();
        pop_pend = 0;
        tick();
        reset_n = 1'b1;
        grants = 0;
        push_grant(4, 9'd141, 4'd2);
        iv_bufid_req[4] = 1'b1;
        wait_grants(1, 20);
        check("post_rst_gcnt", 32'(ov_grant_cnt), 1);
        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
